axi4lite_xbar_n: RTL and testbench
==================================

Name: axi4lite_xbar_n

Overview:
Parametrised 1-master to N-slave AXI4-Lite crossbar. It sits between the memory-access arbiter and the peripheral/memory slaves, and generalises the fixed UART/SRAM split to NUM_SLAVES address windows. Each window is a base/mask pair. Unmapped accesses complete locally with DECERR instead of being routed to a default slave. Read and write paths are independent; each has one outstanding transaction, tracked by a small FSM.

Parameters:
ADDR_WIDTH, 32, address width of all AR/AW channels.
DATA_WIDTH, 32, data width of R/W channels. WSTRB width is DATA_WIDTH/8.
NUM_SLAVES, 2, number of downstream slave ports (1..16).
SLV_BASE, {32'h0000_0000, 32'ha000_03f8}, NUM_SLAVES*ADDR_WIDTH flattened bases. Slave i occupies bits [i*AW +: AW].
SLV_MASK, {32'h0000_0000, 32'hffff_fffc}, flattened masks. Slave i matches when (addr & mask_i) == (base_i & mask_i).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous active-low reset.
arvalid/arready  in/out  1  master read-address handshake.
araddr  in  ADDR_WIDTH  master read address.
rvalid/rready  out/in  1  master read-data handshake.
rdata  out  DATA_WIDTH  read data.
rresp  out  2  read response.
awvalid/awready  in/out  1  master write-address handshake.
awaddr  in  ADDR_WIDTH  master write address.
wvalid/wready  in/out  1  master write-data handshake.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  write strobes.
bvalid/bready  out/in  1  master write-response handshake.
bresp  out  2  write response.
s_arvalid/s_arready  out/in  NUM_SLAVES  per-slave AR handshake.
s_araddr  out  NUM_SLAVES*ADDR_WIDTH  araddr replicated to every slave.
s_rvalid/s_rready  in/out  NUM_SLAVES  per-slave R handshake.
s_rdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data.
s_rresp  in  NUM_SLAVES*2  per-slave read response.
s_awvalid/s_awready  out/in  NUM_SLAVES  per-slave AW handshake.
s_awaddr  out  NUM_SLAVES*ADDR_WIDTH  awaddr replicated.
s_wvalid/s_wready  out/in  NUM_SLAVES  per-slave W handshake.
s_wdata  out  NUM_SLAVES*DATA_WIDTH  wdata replicated.
s_wstrb  out  NUM_SLAVES*DATA_WIDTH/8  wstrb replicated.
s_bvalid/s_bready  in/out  NUM_SLAVES  per-slave B handshake.
s_bresp  in  NUM_SLAVES*2  per-slave write response.

Behaviour:
- Decode is combinational on the address. The lowest-index matching slave wins. No match means decode error.
- Read FSM states: R_IDLE, R_DATA, R_ERR. The selected index is registered on AR handshake.
  - R_IDLE: s_arvalid[sel] = arvalid; arready = s_arready[sel], zero-latency pass-through.
  - R_IDLE, unmapped address: arready = 1, no s_arvalid is asserted, go to R_ERR.
  - R_IDLE, mapped address: on AR handshake go to R_DATA.
  - R_DATA: rvalid/rdata/rresp are muxed from the latched slave; s_rready[sel] = rready. On R handshake go to R_IDLE.
  - R_ERR: rvalid = 1, rresp = 2'b11, rdata = 0. On rready go to R_IDLE.
  - arready = 0 outside R_IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP, W_EDATA, W_ERESP.
  - W_IDLE: routes AW the same way as reads. On handshake go to W_DATA, or W_EDATA if unmapped.
  - W_DATA: s_wvalid[sel] = wvalid; wready = s_wready[sel]. On handshake go to W_RESP.
  - W_RESP: B is muxed from the latched slave. On handshake go to W_IDLE.
  - W_EDATA: wready = 1, data discarded. Go to W_ERESP.
  - W_ERESP: bvalid = 1, bresp = 2'b11. On bready go to W_IDLE.
  - W before AW is not accepted: wready = 0 in W_IDLE.
- Read and write FSMs are fully independent and may target the same or different slaves concurrently.
- Unselected slaves see valid/ready = 0 at all times.
- Reset (rst low, asynchronous) puts both FSMs in idle. All valid/ready outputs are 0, rresp/bresp are 0, rdata is 0.
- Reset mid-transaction abandons the transaction with no response.
- After reset release, the first handshake is possible in the same cycle arvalid/awvalid is seen.
- Overlapping windows are legal; priority resolves them. A mask of 0 is a catch-all.

Test Plan:
- Read 0xa000_03f8: slave0 arvalid=1, slave1 arvalid=0. Slave0 returns rdata=0x41, rresp=0 -> master rdata=0x41, rvalid for exactly one cycle with rready=1.
- Read 0x8000_0000 with slave1 arready held low 3 cycles -> arready low 3 cycles. Then one handshake. A second arvalid is held off (arready=0) until the R handshake completes.
- Write 0x8000_0010, wdata 0xdeadbeef, wstrb 0xf -> slave1 sees AW then W. bresp=0 returned. Slave0 s_awvalid/s_wvalid stay 0 throughout.
- Set NUM_SLAVES=3 with no catch-all mask. Read 0x1234_0000 (unmapped) -> arready=1 at once, next cycle rvalid=1, rresp=2'b11, rdata=0. No s_arvalid asserted.
- Unmapped write -> wready=1 for one cycle, then bvalid=1, bresp=2'b11. Hold bready=0 for 4 cycles -> bvalid stays 1.
- Concurrent UART write and SRAM read complete independently. Asserting rst low while in R_DATA -> rvalid=0 and arready=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/axi4lite_xbar_n.sv
// One-master to N-slave AXI4-Lite crossbar with base/mask address windows.
// Unmapped accesses are answered locally with DECERR; reads and writes each allow one outstanding transaction.
module axi4lite_xbar_n #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h0000_0000, 32'ha000_03f8},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'h0000_0000, 32'hffff_fffc}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arvalid,
  output logic                             arready,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic                             wvalid,
  output logic                             wready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  output logic                             bvalid,
  input  logic                             bready,
  output logic [1:0]                       bresp,
  output logic [NUM_SLAVES-1:0]            s_arvalid,
  input  logic [NUM_SLAVES-1:0]            s_arready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_SLAVES-1:0]            s_rvalid,
  output logic [NUM_SLAVES-1:0]            s_rready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES*2-1:0]          s_rresp,
  output logic [NUM_SLAVES-1:0]            s_awvalid,
  input  logic [NUM_SLAVES-1:0]            s_awready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_awaddr,
  output logic [NUM_SLAVES-1:0]            s_wvalid,
  input  logic [NUM_SLAVES-1:0]            s_wready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wdata,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] s_wstrb,
  input  logic [NUM_SLAVES-1:0]            s_bvalid,
  output logic [NUM_SLAVES-1:0]            s_bready,
  input  logic [NUM_SLAVES*2-1:0]          s_bresp
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] R_IDLE = 2'd0, R_DATA = 2'd1, R_ERR = 2'd2;
  localparam logic [2:0] W_IDLE = 3'd0, W_DATA = 3'd1, W_RESP = 3'd2,
                         W_EDATA = 3'd3, W_ERESP = 3'd4;

  // Valid/ready handshake: a beat transfers on a rising edge where valid and ready are both high.
  // Scanning from the top index down lets the lowest matching window win.
  function automatic logic [SW:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic          hit;
    logic [SW-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((a & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit = 1'b1;
        idx = SW'(i);
      end
    end
    return {hit, idx};
  endfunction

  logic          w_ar_hit, w_aw_hit;
  logic [SW-1:0] w_ar_idx, w_aw_idx;
  logic [1:0]    r_rstate;
  logic [2:0]    r_wstate;
  logic [SW-1:0] r_rsel, r_wsel;

  assign {w_ar_hit, w_ar_idx} = decode(araddr);
  assign {w_aw_hit, w_aw_idx} = decode(awaddr);

  assign s_araddr = {NUM_SLAVES{araddr}};
  assign s_awaddr = {NUM_SLAVES{awaddr}};
  assign s_wdata  = {NUM_SLAVES{wdata}};
  assign s_wstrb  = {NUM_SLAVES{wstrb}};

  // Outputs are gated by rst so an asynchronous reset silences the bus immediately.
  always_comb begin
    s_arvalid = '0;
    arready   = 1'b0;
    s_rready  = '0;
    rvalid    = 1'b0;
    rdata     = '0;
    rresp     = 2'b00;
    if (rst) begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hit) begin
            s_arvalid[w_ar_idx] = arvalid;
            arready             = s_arready[w_ar_idx];
          end else begin
            arready = 1'b1;
          end
        end
        R_DATA: begin
          rvalid           = s_rvalid[r_rsel];
          rdata            = s_rdata[r_rsel*DATA_WIDTH +: DATA_WIDTH];
          rresp            = s_rresp[r_rsel*2 +: 2];
          s_rready[r_rsel] = rready;
        end
        R_ERR: begin
          rvalid = 1'b1;
          rresp  = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_rsel   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (arvalid && arready) begin
          r_rsel   <= w_ar_idx;
          r_rstate <= w_ar_hit ? R_DATA : R_ERR;
        end
        R_DATA:  if (rvalid && rready) r_rstate <= R_IDLE;
        R_ERR:   if (rready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    s_awvalid = '0;
    awready   = 1'b0;
    s_wvalid  = '0;
    wready    = 1'b0;
    s_bready  = '0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    if (rst) begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hit) begin
            s_awvalid[w_aw_idx] = awvalid;
            awready             = s_awready[w_aw_idx];
          end else begin
            awready = 1'b1;
          end
        end
        W_DATA: begin
          s_wvalid[r_wsel] = wvalid;
          wready           = s_wready[r_wsel];
        end
        W_RESP: begin
          bvalid           = s_bvalid[r_wsel];
          bresp            = s_bresp[r_wsel*2 +: 2];
          s_bready[r_wsel] = bready;
        end
        W_EDATA: wready = 1'b1;
        W_ERESP: begin
          bvalid = 1'b1;
          bresp  = 2'b11;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_wsel   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (awvalid && awready) begin
          r_wsel   <= w_aw_idx;
          r_wstate <= w_aw_hit ? W_DATA : W_EDATA;
        end
        W_DATA:  if (wvalid && wready) r_wstate <= W_RESP;
        W_RESP:  if (bvalid && bready) r_wstate <= W_IDLE;
        W_EDATA: if (wvalid) r_wstate <= W_ERESP;
        W_ERESP: if (bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_xbar_n.sv
// Directed and randomized bench for axi4lite_xbar_n with three slaves and overlapping windows
// (UART word, SRAM 0x8xxx_xxxx, and a wider 0x8-0xB region that only wins where the others miss).
module tb_axi4lite_xbar_n;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;
  logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic [N-1:0] s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N*32-1:0] s_araddr, s_awaddr, s_rdata, s_wdata;
  logic [N*4-1:0]  s_wstrb;
  logic [N*2-1:0]  s_rresp, s_bresp;

  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] mdl_base [N] = '{32'ha000_03f8, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] mdl_mask [N] = '{32'hffff_fffc, 32'hf000_0000, 32'hc000_0000};

  axi4lite_xbar_n #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(N),
    .SLV_BASE({32'h8000_0000, 32'h8000_0000, 32'ha000_03f8}),
    .SLV_MASK({32'hc000_0000, 32'hf000_0000, 32'hffff_fffc})
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // reference model: first window (lowest index) whose masked base equals the masked address
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mdl_mask[i]) == (mdl_base[i] & mdl_mask[i])) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 4))
      0: a = 32'ha000_03f8 | 32'($urandom_range(0, 3));
      1: a[31:28] = 4'h8;
      2: a[31:28] = ($urandom_range(0, 1) == 0) ? 4'h9 : 4'hb;
      3: a[31:28] = 4'($urandom_range(0, 7));
      default: a[31:28] = 4'ha;
    endcase
    return a;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one read; ard = slave arready delay, sd = slave rvalid delay, rrd = extra rready delay
  task automatic do_read(input logic [31:0] a, input int ard, input int sd, input int rrd,
                         input logic [31:0] rd, input logic [1:0] rr);
    int idx;
    logic [N-1:0] ev;
    logic exp_v;
    idx = ref_decode(a);
    ev  = onehot(idx);
    araddr  = a;
    arvalid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_arready = (c >= ard) ? {N{1'b1}} : '0;
      #1;
      chk("ar_s_arvalid", s_arvalid, ev);
      chk("ar_arready", arready, (idx < 0) || (c >= ard));
      if (idx >= 0) chk("ar_s_araddr", s_araddr[idx*32 +: 32], a);
      if ((idx < 0) || (c >= ard)) begin
        exp_q.push_back((idx < 0) ? 32'h0 : rd);
        tick();
        break;
      end
      tick();
    end
    araddr = $urandom;
    for (int c = 0; c < 16; c++) begin
      s_rvalid = N'($urandom_range(0, 7));
      s_rdata  = {$urandom, $urandom, $urandom};
      s_rresp  = 6'($urandom_range(0, 63));
      if (idx >= 0) begin
        s_rvalid[idx]         = (c >= sd);
        s_rdata[idx*32 +: 32] = rd;
        s_rresp[idx*2 +: 2]   = rr;
        rready = (c >= sd + rrd);
        exp_v  = (c >= sd);
      end else begin
        rready = (c >= rrd);
        exp_v  = 1'b1;
      end
      #1;
      chk("r_rvalid", rvalid, exp_v);
      chk("r_arready_held", arready, 1'b0);
      chk("r_s_arvalid_held", s_arvalid, '0);
      chk("r_s_rready", s_rready, rready ? ev : '0);
      if (exp_v) begin
        chk("r_rdata", rdata, exp_q[0]);
        chk("r_rresp", rresp, (idx < 0) ? 2'b11 : rr);
      end
      if (exp_v && rready) begin
        void'(exp_q.pop_front());
        tick();
        break;
      end
      tick();
    end
    arvalid = 1'b0;
    #1;
    chk("r_one_cycle", rvalid, 1'b0);
    rready   = 1'b0;
    s_rvalid = '0;
  endtask

  // driver: one write; awd = slave awready delay, wvd = master wvalid delay, sd/bd as for reads
  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int awd, input int wvd, input int sd, input int bd,
                          input logic [1:0] br);
    int idx;
    logic [N-1:0] ev;
    logic exp_v;
    idx = ref_decode(a);
    ev  = onehot(idx);
    awaddr = a;
    awvalid = 1'b1;
    wvalid = 1'b1;
    wdata  = wd;
    wstrb  = ws;
    s_wready = {N{1'b1}};
    for (int c = 0; c < 12; c++) begin
      s_awready = (c >= awd) ? {N{1'b1}} : '0;
      #1;
      chk("aw_s_awvalid", s_awvalid, ev);
      chk("aw_awready", awready, (idx < 0) || (c >= awd));
      chk("aw_wready_before_aw", wready, 1'b0);
      chk("aw_s_wvalid_before_aw", s_wvalid, '0);
      if (idx >= 0) chk("aw_s_awaddr", s_awaddr[idx*32 +: 32], a);
      if ((idx < 0) || (c >= awd)) begin
        tick();
        break;
      end
      tick();
    end
    awaddr = $urandom;
    for (int c = 0; c < 12; c++) begin
      wvalid   = (c >= wvd);
      s_wready = N'($urandom_range(0, 7)) | ev;
      #1;
      chk("w_awready_held", awready, 1'b0);
      chk("w_s_awvalid_held", s_awvalid, '0);
      chk("w_wready", wready, 1'b1);
      chk("w_s_wvalid", s_wvalid, wvalid ? ev : '0);
      if (idx >= 0) begin
        chk("w_s_wdata", s_wdata[idx*32 +: 32], wd);
        chk("w_s_wstrb", s_wstrb[idx*4 +: 4], ws);
      end
      if (wvalid) begin
        tick();
        break;
      end
      tick();
    end
    wdata = $urandom;
    for (int c = 0; c < 16; c++) begin
      s_bvalid = N'($urandom_range(0, 7));
      s_bresp  = 6'($urandom_range(0, 63));
      if (idx >= 0) begin
        s_bvalid[idx]       = (c >= sd);
        s_bresp[idx*2 +: 2] = br;
        bready = (c >= sd + bd);
        exp_v  = (c >= sd);
      end else begin
        bready = (c >= bd);
        exp_v  = 1'b1;
      end
      #1;
      chk("b_bvalid", bvalid, exp_v);
      chk("b_wready_after_w", wready, 1'b0);
      chk("b_s_wvalid_held", s_wvalid, '0);
      chk("b_awready_held", awready, 1'b0);
      chk("b_s_bready", s_bready, bready ? ev : '0);
      if (exp_v) chk("b_bresp", bresp, (idx < 0) ? 2'b11 : br);
      if (exp_v && bready) begin
        tick();
        break;
      end
      tick();
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    #1;
    chk("b_one_cycle", bvalid, 1'b0);
    bready   = 1'b0;
    s_bvalid = '0;
  endtask

  task automatic clear_inputs();
    arvalid = 0; araddr = '0; rready = 0; awvalid = 0; awaddr = '0;
    wvalid = 0; wdata = '0; wstrb = '0; bready = 0;
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
  endtask

  initial begin
    // reset with every input pushing towards activity
    clear_inputs();
    rst = 1'b0;
    arvalid = 1; araddr = 32'h8000_0000; s_arready = '1;
    awvalid = 1; awaddr = 32'h1234_0000; s_awready = '1;
    wvalid = 1; s_wready = '1; rready = 1; bready = 1;
    s_rvalid = '1; s_bvalid = '1; s_rdata = '1; s_rresp = '1; s_bresp = '1;
    #3;
    chk("rst_arready", arready, 1'b0);
    chk("rst_s_arvalid", s_arvalid, '0);
    chk("rst_awready_unmapped", awready, 1'b0);
    chk("rst_s_awvalid", s_awvalid, '0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_s_rready", s_rready, '0);
    chk("rst_s_bready", s_bready, '0);
    tick();
    tick();
    clear_inputs();
    rst = 1'b1;

    // UART read, first handshake right after reset release
    do_read(32'ha000_03f8, 0, 0, 0, 32'h41, 2'b00);
    // SRAM read with slave arready held low for 3 cycles
    do_read(32'h8000_0000, 3, 1, 0, $urandom, 2'b00);
    // SRAM write
    do_write(32'h8000_0010, 32'hdead_beef, 4'hf, 0, 0, 1, 0, 2'b00);
    // unmapped read and write, bready held low 4 cycles
    do_read(32'h1234_0000, 0, 0, 0, $urandom, 2'b00);
    do_write(32'h1234_0000, $urandom, 4'h3, 0, 0, 0, 4, 2'b00);
    // overlap: 0x9xxx_xxxx only hits the wide window, 0x8xxx_xxxx goes to SRAM
    do_read(32'h9000_0004, 1, 2, 1, $urandom, 2'b10);
    do_write(32'ha000_03fb, $urandom, 4'h1, 2, 1, 0, 2, 2'b01);

    // concurrent UART write and SRAM read
    araddr = 32'h8000_0020; arvalid = 1; s_arready = '1;
    awaddr = 32'ha000_03f8; awvalid = 1; s_awready = '1;
    #1;
    chk("cc_arready", arready, 1'b1);
    chk("cc_awready", awready, 1'b1);
    chk("cc_s_arvalid", s_arvalid, 3'b010);
    chk("cc_s_awvalid", s_awvalid, 3'b001);
    tick();
    arvalid = 0; awvalid = 0;
    wvalid = 1; wdata = 32'h0000_0055; wstrb = 4'h1; s_wready = '1;
    s_rvalid = 3'b010; s_rdata[32 +: 32] = 32'h1357_9bdf; s_rresp[2 +: 2] = 2'b00; rready = 1;
    #1;
    chk("cc_wready", wready, 1'b1);
    chk("cc_s_wvalid", s_wvalid, 3'b001);
    chk("cc_rvalid", rvalid, 1'b1);
    chk("cc_rdata", rdata, 32'h1357_9bdf);
    tick();
    wvalid = 0; s_rvalid = '0; rready = 0;
    s_bvalid = 3'b001; s_bresp = '0; bready = 1;
    #1;
    chk("cc_bvalid", bvalid, 1'b1);
    chk("cc_bresp", bresp, 2'b00);
    chk("cc_rvalid_done", rvalid, 1'b0);
    tick();
    s_bvalid = '0; bready = 0;
    #1;
    chk("cc_bvalid_done", bvalid, 1'b0);

    // asynchronous reset while in R_DATA
    araddr = 32'h8000_0000; arvalid = 1; s_arready = '1;
    tick();
    araddr = 32'h1234_0000; s_rvalid = 3'b010; rready = 1;
    #1;
    chk("mid_rvalid_before", rvalid, 1'b1);
    chk("mid_arready_before", arready, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rvalid_async", rvalid, 1'b0);
    chk("mid_arready_async", arready, 1'b0);
    chk("mid_s_rready_async", s_rready, '0);
    clear_inputs();
    tick();
    rst = 1'b1;
    s_rvalid = 3'b010;
    #1;
    chk("mid_no_response", rvalid, 1'b0);
    s_rvalid = '0;
    tick();

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom, 2'($urandom_range(0, 3)));
      else
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
